// File: rtl/mem_map_pkg.sv
// Shared memory map: address regions, target indices and router state encoding.
package mem_map_pkg;

   localparam int unsigned ADDR_W   = 32;
   localparam int unsigned OFFS_W   = 16;
   localparam int unsigned REGION_W = 16;
   localparam int unsigned NUM_TGT  = 4;
   localparam int unsigned SEL_W    = 2;

   localparam logic [REGION_W-1:0] REGION_BRAM   = 16'h0000;
   localparam logic [REGION_W-1:0] REGION_SRAM   = 16'h0001;
   localparam logic [REGION_W-1:0] REGION_FLASH  = 16'h0002;
   localparam logic [REGION_W-1:0] REGION_PERIPH = 16'h0003;

   localparam logic [SEL_W-1:0] TGT_BRAM   = 2'd0;
   localparam logic [SEL_W-1:0] TGT_SRAM   = 2'd1;
   localparam logic [SEL_W-1:0] TGT_FLASH  = 2'd2;
   localparam logic [SEL_W-1:0] TGT_PERIPH = 2'd3;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_RESP   = 2'd2
   } router_state_e;

endpackage

// File: rtl/memory_decoder.sv
// Region decoder: maps the upper address half onto one of four targets or flags an unmapped region.
module memory_decoder
   import mem_map_pkg::*;
(
   input  logic [REGION_W-1:0] i_region,
   output logic                o_sel_bram,
   output logic                o_sel_sram,
   output logic                o_sel_flash,
   output logic                o_sel_periph,
   output logic                o_error
);

   assign o_sel_bram   = (i_region == REGION_BRAM);
   assign o_sel_sram   = (i_region == REGION_SRAM);
   assign o_sel_flash  = (i_region == REGION_FLASH);
   assign o_sel_periph = (i_region == REGION_PERIPH);
   assign o_error      = ~(o_sel_bram | o_sel_sram | o_sel_flash | o_sel_periph);

endmodule

// File: rtl/memory_bus_router.sv
// Single-outstanding router from the CPU load/store port to BRAM/SRAM/flash/peripheral targets.
module memory_bus_router
   import mem_map_pkg::*;
#(
   parameter int unsigned DATA_W  = 32,
   parameter int unsigned TIMEOUT = 255
)
(
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      req_valid,
   output logic                      req_ready,
   input  logic [ADDR_W-1:0]         req_addr,
   input  logic                      req_write,
   input  logic [DATA_W-1:0]         req_wdata,
   input  logic [DATA_W/8-1:0]       req_wstrb,
   output logic                      resp_valid,
   output logic [DATA_W-1:0]         resp_rdata,
   output logic                      resp_error,
   output logic [NUM_TGT-1:0]        tgt_valid,
   output logic [OFFS_W-1:0]         tgt_addr,
   output logic                      tgt_write,
   output logic [DATA_W-1:0]         tgt_wdata,
   output logic [DATA_W/8-1:0]       tgt_wstrb,
   input  logic [NUM_TGT-1:0]        tgt_ack,
   input  logic [NUM_TGT*DATA_W-1:0] tgt_rdata
);

   localparam int unsigned STRB_W = DATA_W / 8;
   localparam int unsigned CNT_W  = $clog2(TIMEOUT + 1);

   router_state_e       r_state, w_state_nxt;
   logic [ADDR_W-1:0]   r_addr, w_addr_nxt;
   logic                r_write, w_write_nxt;
   logic [DATA_W-1:0]   r_wdata, w_wdata_nxt;
   logic [STRB_W-1:0]   r_wstrb, w_wstrb_nxt;
   logic [SEL_W-1:0]    r_sel, w_sel_nxt;
   logic                r_err, w_err_nxt;
   logic [CNT_W-1:0]    r_cnt, w_cnt_nxt;
   logic [NUM_TGT-1:0]  r_tgt_valid, w_tgt_valid_nxt;
   logic                r_resp_valid, w_resp_valid_nxt;
   logic [DATA_W-1:0]   r_resp_rdata, w_resp_rdata_nxt;
   logic                r_resp_error, w_resp_error_nxt;

   logic [ADDR_W-1:0]   w_dec_addr;
   logic                w_sel_bram, w_sel_sram, w_sel_flash, w_sel_periph, w_dec_error;
   logic [NUM_TGT-1:0]  w_sel_onehot;
   logic [SEL_W-1:0]    w_sel;
   logic                w_err_in;
   logic                w_ack_sel;
   logic [DATA_W-1:0]   w_rdata_sel;

   // Decode the address being latched while idle so tgt_valid can be registered at accept
   assign w_dec_addr = (r_state == ST_IDLE) ? req_addr : r_addr;

   memory_decoder u_decoder (
      .i_region     (w_dec_addr[ADDR_W-1 -: REGION_W]),
      .o_sel_bram   (w_sel_bram),
      .o_sel_sram   (w_sel_sram),
      .o_sel_flash  (w_sel_flash),
      .o_sel_periph (w_sel_periph),
      .o_error      (w_dec_error)
   );

   assign w_sel_onehot[TGT_BRAM]   = w_sel_bram;
   assign w_sel_onehot[TGT_SRAM]   = w_sel_sram;
   assign w_sel_onehot[TGT_FLASH]  = w_sel_flash;
   assign w_sel_onehot[TGT_PERIPH] = w_sel_periph;
   assign w_sel    = {w_sel_flash | w_sel_periph, w_sel_sram | w_sel_periph};
   assign w_err_in = w_dec_error | (req_addr[1:0] != 2'b00);
   assign w_ack_sel = tgt_ack[r_sel];

   // Pick the read-data slice of the selected target
   always_comb begin
      w_rdata_sel = '0;
      for (int i = 0; i < int'(NUM_TGT); i++) begin
         if (r_sel == SEL_W'(i)) w_rdata_sel = tgt_rdata[i*DATA_W +: DATA_W];
      end
   end

   // Next-state and next-register values for the request/response sequence
   always_comb begin
      w_state_nxt      = r_state;
      w_addr_nxt       = r_addr;
      w_write_nxt      = r_write;
      w_wdata_nxt      = r_wdata;
      w_wstrb_nxt      = r_wstrb;
      w_sel_nxt        = r_sel;
      w_err_nxt        = r_err;
      w_cnt_nxt        = r_cnt;
      w_tgt_valid_nxt  = r_tgt_valid;
      w_resp_valid_nxt = 1'b0;
      w_resp_rdata_nxt = r_resp_rdata;
      w_resp_error_nxt = r_resp_error;
      unique case (r_state)
         ST_IDLE: begin
            if (req_valid) begin
               w_addr_nxt      = req_addr;
               w_write_nxt     = req_write;
               w_wdata_nxt     = req_wdata;
               w_wstrb_nxt     = req_wstrb;
               w_sel_nxt       = w_sel;
               w_err_nxt       = w_err_in;
               w_cnt_nxt       = '0;
               w_tgt_valid_nxt = w_err_in ? '0 : w_sel_onehot;
               w_state_nxt     = ST_ACCESS;
            end
         end
         ST_ACCESS: begin
            if (r_err) begin
               w_resp_valid_nxt = 1'b1;
               w_resp_error_nxt = 1'b1;
               w_resp_rdata_nxt = '0;
               w_state_nxt      = ST_RESP;
            end else if (w_ack_sel) begin
               w_tgt_valid_nxt  = '0;
               w_resp_valid_nxt = 1'b1;
               w_resp_error_nxt = 1'b0;
               w_resp_rdata_nxt = r_write ? '0 : w_rdata_sel;
               w_state_nxt      = ST_RESP;
            end else if (r_cnt == CNT_W'(TIMEOUT - 1)) begin
               w_tgt_valid_nxt  = '0;
               w_resp_valid_nxt = 1'b1;
               w_resp_error_nxt = 1'b1;
               w_resp_rdata_nxt = '0;
               w_state_nxt      = ST_RESP;
            end else begin
               w_cnt_nxt = r_cnt + CNT_W'(1);
            end
         end
         ST_RESP: begin
            w_resp_rdata_nxt = '0;
            w_resp_error_nxt = 1'b0;
            w_state_nxt      = ST_IDLE;
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // State and datapath registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= ST_IDLE;
         r_addr       <= '0;
         r_write      <= 1'b0;
         r_wdata      <= '0;
         r_wstrb      <= '0;
         r_sel        <= '0;
         r_err        <= 1'b0;
         r_cnt        <= '0;
         r_tgt_valid  <= '0;
         r_resp_valid <= 1'b0;
         r_resp_rdata <= '0;
         r_resp_error <= 1'b0;
      end else begin
         r_state      <= w_state_nxt;
         r_addr       <= w_addr_nxt;
         r_write      <= w_write_nxt;
         r_wdata      <= w_wdata_nxt;
         r_wstrb      <= w_wstrb_nxt;
         r_sel        <= w_sel_nxt;
         r_err        <= w_err_nxt;
         r_cnt        <= w_cnt_nxt;
         r_tgt_valid  <= w_tgt_valid_nxt;
         r_resp_valid <= w_resp_valid_nxt;
         r_resp_rdata <= w_resp_rdata_nxt;
         r_resp_error <= w_resp_error_nxt;
      end
   end

   assign req_ready  = (r_state == ST_IDLE) && !rst;
   assign resp_valid = r_resp_valid;
   assign resp_rdata = r_resp_rdata;
   assign resp_error = r_resp_error;
   assign tgt_valid  = r_tgt_valid;
   assign tgt_addr   = r_addr[OFFS_W-1:0];
   assign tgt_write  = r_write;
   assign tgt_wdata  = r_wdata;
   assign tgt_wstrb  = r_wstrb;

endmodule

// File: tb/tb_memory_bus_router.sv
// Directed bench for memory_bus_router with TIMEOUT=8.
module tb_memory_bus_router;

   localparam int unsigned DATA_W  = 32;
   localparam int unsigned STRB_W  = DATA_W / 8;
   localparam int unsigned TIMEOUT = 8;

   logic                  clk;
   logic                  rst;
   logic                  req_valid;
   logic                  req_ready;
   logic [31:0]           req_addr;
   logic                  req_write;
   logic [DATA_W-1:0]     req_wdata;
   logic [STRB_W-1:0]     req_wstrb;
   logic                  resp_valid;
   logic [DATA_W-1:0]     resp_rdata;
   logic                  resp_error;
   logic [3:0]            tgt_valid;
   logic [15:0]           tgt_addr;
   logic                  tgt_write;
   logic [DATA_W-1:0]     tgt_wdata;
   logic [STRB_W-1:0]     tgt_wstrb;
   logic [3:0]            tgt_ack;
   logic [4*DATA_W-1:0]   tgt_rdata;

   int n_cmp = 0;
   int n_err = 0;

   logic [31:0] b2b_addr [3];
   logic [31:0] b2b_exp  [3];

   memory_bus_router #(.DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_addr   (req_addr),
      .req_write  (req_write),
      .req_wdata  (req_wdata),
      .req_wstrb  (req_wstrb),
      .resp_valid (resp_valid),
      .resp_rdata (resp_rdata),
      .resp_error (resp_error),
      .tgt_valid  (tgt_valid),
      .tgt_addr   (tgt_addr),
      .tgt_write  (tgt_write),
      .tgt_wdata  (tgt_wdata),
      .tgt_wstrb  (tgt_wstrb),
      .tgt_ack    (tgt_ack),
      .tgt_rdata  (tgt_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Present one request for a single cycle; returns just after the accept edge E0
   task automatic issue(input logic [31:0] a, input logic w, input logic [31:0] d, input logic [3:0] s);
      req_valid = 1'b1;
      req_addr  = a;
      req_write = w;
      req_wdata = d;
      req_wstrb = s;
      tick();
      req_valid = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; req_valid = 1'b0; req_addr = '0; req_write = 1'b0;
      req_wdata = '0; req_wstrb = '0; tgt_ack = '0; tgt_rdata = '0;
      b2b_addr[0] = 32'h0000_0100; b2b_exp[0] = 32'hA0A0_A0A0;
      b2b_addr[1] = 32'h0001_0200; b2b_exp[1] = 32'hB1B1_B1B1;
      b2b_addr[2] = 32'h0002_0300; b2b_exp[2] = 32'hC2C2_C2C2;

      // reset state
      tick(); tick();
      chk("rst_ready", 64'(req_ready), 64'd0);
      chk("rst_tgt_valid", 64'(tgt_valid), 64'd0);
      chk("rst_resp_valid", 64'(resp_valid), 64'd0);
      chk("rst_rdata", 64'(resp_rdata), 64'd0);
      chk("rst_error", 64'(resp_error), 64'd0);
      chk("rst_tgt_addr", 64'(tgt_addr), 64'd0);
      rst = 1'b0;
      #1;
      chk("ready_after_rst", 64'(req_ready), 64'd1);

      // BRAM read, ack one cycle later
      issue(32'h0000_0010, 1'b0, 32'h0, 4'h0);
      chk("bram_tgt_valid", 64'(tgt_valid), 64'h1);
      chk("bram_tgt_addr", 64'(tgt_addr), 64'h0010);
      chk("bram_tgt_write", 64'(tgt_write), 64'd0);
      chk("bram_ready_busy", 64'(req_ready), 64'd0);
      chk("bram_resp_early", 64'(resp_valid), 64'd0);
      tgt_rdata = {32'h0, 32'h0, 32'h0, 32'hDEAD_BEEF};
      tgt_ack = 4'b0001;
      tick();
      tgt_ack = 4'b0000;
      chk("bram_resp_valid", 64'(resp_valid), 64'd1);
      chk("bram_rdata", 64'(resp_rdata), 64'hDEAD_BEEF);
      chk("bram_error", 64'(resp_error), 64'd0);
      chk("bram_tgt_drop", 64'(tgt_valid), 64'd0);
      tick();
      chk("bram_resp_pulse", 64'(resp_valid), 64'd0);
      chk("bram_ready_back", 64'(req_ready), 64'd1);

      // SRAM write, ack after 5 cycles of tgt_valid
      tgt_rdata = {4{32'h55AA_55AA}};
      issue(32'h0001_0004, 1'b1, 32'h1234_5678, 4'b0011);
      for (int i = 0; i < 5; i++) begin
         chk("sram_tgt_valid", 64'(tgt_valid), 64'h2);
         chk("sram_tgt_addr", 64'(tgt_addr), 64'h0004);
         chk("sram_tgt_wdata", 64'(tgt_wdata), 64'h1234_5678);
         chk("sram_tgt_wstrb", 64'(tgt_wstrb), 64'h3);
         chk("sram_tgt_write", 64'(tgt_write), 64'd1);
         chk("sram_resp_early", 64'(resp_valid), 64'd0);
         if (i == 4) tgt_ack = 4'b0010;
         tick();
      end
      tgt_ack = 4'b0000;
      chk("sram_resp_valid", 64'(resp_valid), 64'd1);
      chk("sram_rdata", 64'(resp_rdata), 64'd0);
      chk("sram_error", 64'(resp_error), 64'd0);
      tick();
      chk("sram_resp_pulse", 64'(resp_valid), 64'd0);

      // unmapped region
      issue(32'h0005_0000, 1'b0, 32'h0, 4'h0);
      chk("dec_tgt_valid", 64'(tgt_valid), 64'd0);
      tick();
      chk("dec_resp_valid", 64'(resp_valid), 64'd1);
      chk("dec_error", 64'(resp_error), 64'd1);
      chk("dec_rdata", 64'(resp_rdata), 64'd0);
      chk("dec_tgt_valid2", 64'(tgt_valid), 64'd0);
      tick();
      chk("dec_ready", 64'(req_ready), 64'd1);

      // misaligned BRAM address
      issue(32'h0000_0002, 1'b0, 32'h0, 4'h0);
      chk("mis_tgt_valid", 64'(tgt_valid), 64'd0);
      tick();
      chk("mis_resp_valid", 64'(resp_valid), 64'd1);
      chk("mis_error", 64'(resp_error), 64'd1);
      chk("mis_rdata", 64'(resp_rdata), 64'd0);
      chk("mis_tgt_valid2", 64'(tgt_valid), 64'd0);
      tick();

      // flash read timing out, stray acks on other targets
      tgt_rdata = {32'hD3D3_D3D3, 32'hC2C2_C2C2, 32'hB1B1_B1B1, 32'hA0A0_A0A0};
      tgt_ack = 4'b1011;
      issue(32'h0002_0000, 1'b0, 32'h0, 4'h0);
      for (int i = 0; i < 8; i++) begin
         chk("to_tgt_valid", 64'(tgt_valid), 64'h4);
         chk("to_resp_early", 64'(resp_valid), 64'd0);
         tick();
      end
      chk("to_resp_valid", 64'(resp_valid), 64'd1);
      chk("to_error", 64'(resp_error), 64'd1);
      chk("to_rdata", 64'(resp_rdata), 64'd0);
      chk("to_tgt_drop", 64'(tgt_valid), 64'd0);
      tick();
      tgt_ack = 4'b0000;
      chk("to_ready", 64'(req_ready), 64'd1);

      // flash read with ack on the same edge the timeout would fire
      issue(32'h0002_0010, 1'b0, 32'h0, 4'h0);
      for (int i = 0; i < 8; i++) begin
         chk("ta_tgt_valid", 64'(tgt_valid), 64'h4);
         if (i == 7) tgt_ack = 4'b0100;
         tick();
      end
      tgt_ack = 4'b0000;
      chk("ta_resp_valid", 64'(resp_valid), 64'd1);
      chk("ta_error", 64'(resp_error), 64'd0);
      chk("ta_rdata", 64'(resp_rdata), 64'hC2C2_C2C2);
      tick();

      // reset in the middle of a peripheral read
      issue(32'h0003_0008, 1'b0, 32'h0, 4'h0);
      chk("rr_tgt_valid", 64'(tgt_valid), 64'h8);
      tick();
      chk("rr_tgt_valid2", 64'(tgt_valid), 64'h8);
      tgt_ack = 4'b1000;
      rst = 1'b1;
      tick();
      chk("rr_tgt_cleared", 64'(tgt_valid), 64'd0);
      chk("rr_resp_none", 64'(resp_valid), 64'd0);
      chk("rr_ready_in_rst", 64'(req_ready), 64'd0);
      rst = 1'b0;
      #1;
      chk("rr_ready_after", 64'(req_ready), 64'd1);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("rr_no_resp", 64'(resp_valid), 64'd0);
         chk("rr_no_tgt", 64'(tgt_valid), 64'd0);
      end
      tgt_ack = 4'b0000;
      tgt_rdata = {32'h0, 32'h0, 32'h0, 32'hCAFE_F00D};
      issue(32'h0000_0020, 1'b0, 32'h0, 4'h0);
      chk("rr_bram_tgt_valid", 64'(tgt_valid), 64'h1);
      tgt_ack = 4'b0001;
      tick();
      tgt_ack = 4'b0000;
      chk("rr_bram_resp", 64'(resp_valid), 64'd1);
      chk("rr_bram_rdata", 64'(resp_rdata), 64'hCAFE_F00D);
      chk("rr_bram_error", 64'(resp_error), 64'd0);
      tick();

      // back-to-back reads with req_valid held high and targets always acking
      tgt_rdata = {32'hD3D3_D3D3, 32'hC2C2_C2C2, 32'hB1B1_B1B1, 32'hA0A0_A0A0};
      tgt_ack = 4'b1111;
      req_valid = 1'b1;
      req_write = 1'b0;
      for (int s = 0; s < 9; s++) begin
         if (s % 3 == 0) req_addr = b2b_addr[s/3];
         chk("b2b_ready", 64'(req_ready), 64'(s % 3 == 0));
         chk("b2b_resp_valid", 64'(resp_valid), 64'(s % 3 == 2));
         if (s % 3 == 1) chk("b2b_tgt_addr", 64'(tgt_addr), 64'(b2b_addr[s/3][15:0]));
         if (s % 3 == 2) chk("b2b_rdata", 64'(resp_rdata), 64'(b2b_exp[s/3]));
         tick();
      end
      req_valid = 1'b0;
      tgt_ack = 4'b0000;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
